// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu : handshaked ALU with an iterative shift-add multiplier; rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package details;
  typedef enum logic [2:0] {
    clr_alu  = 3'd0,
    pass_alu = 3'd1,
    add_alu  = 3'd2,
    sub_alu  = 3'd3,
    mul_alu  = 3'd4,
    inc_alu  = 3'd5
  } alu_op_t;
endpackage

module seq_alu
  import details::*;
#(
  parameter int WIDTH    = 12,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  alu_op_t                 selectOp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] c,
  output logic                    zero,
  output logic                    neg,
  output logic                    ovf
);

  localparam int PW = 2*WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     out_valid_q, out_valid_d;
  logic [WIDTH-1:0]         c_q, c_d;
  logic                     zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic [2*WIDTH-1:0]       mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH:0]           mplier_q, mplier_d;
  logic                     msign_q, msign_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  logic                     accept_w;
  logic [PW-1:0]            a_x_w, b_x_w, op_exact_w, mul_exact_w, exact_w;
  logic [WIDTH:0]           a_mag_w, b_mag_w;
  logic                     res_ovf_w;
  logic [WIDTH-1:0]         res_w;

  assign in_ready  = (state_q != MUL) && (!out_valid_q || out_ready);
  assign accept_w  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

  assign a_x_w = {{(PW-WIDTH){a[WIDTH-1]}}, a};
  assign b_x_w = {{(PW-WIDTH){b[WIDTH-1]}}, b};

  // Magnitudes carry one extra bit so that -2^(WIDTH-1) is represented exactly.
  assign a_mag_w = a[WIDTH-1] ? (~{a[WIDTH-1], a} + (WIDTH+1)'(1)) : {a[WIDTH-1], a};
  assign b_mag_w = b[WIDTH-1] ? (~{b[WIDTH-1], b} + (WIDTH+1)'(1)) : {b[WIDTH-1], b};

  assign mul_exact_w = msign_q ? (~{1'b0, acc_q} + PW'(1)) : {1'b0, acc_q};

  always_comb begin
    op_exact_w = '0;
    case (selectOp)
      pass_alu: op_exact_w = b_x_w;
      add_alu:  op_exact_w = a_x_w + b_x_w;
      sub_alu:  op_exact_w = a_x_w - b_x_w;
      inc_alu:  op_exact_w = a_x_w + PW'(1);
      default:  op_exact_w = '0;
    endcase
  end

  // The exact result fits the signed range only if all bits above WIDTH-2 agree.
  assign exact_w   = (state_q == MUL) ? mul_exact_w : op_exact_w;
  assign res_ovf_w = !((&exact_w[PW-1:WIDTH-1]) || !(|exact_w[PW-1:WIDTH-1]));
  assign res_w     = (SATURATE && res_ovf_w) ? (exact_w[PW-1] ? SMIN : SMAX)
                                             : exact_w[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    msign_d     = msign_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept_w) begin
          if (selectOp == mul_alu) begin
            state_d     = MUL;
            out_valid_d = 1'b0;
            mcand_d     = {{(WIDTH-1){1'b0}}, a_mag_w};
            mplier_d    = b_mag_w;
            acc_d       = '0;
            msign_d     = a[WIDTH-1] ^ b[WIDTH-1];
            cnt_d       = '0;
          end else begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            c_d         = res_w;
            zero_d      = (res_w == '0);
            neg_d       = res_w[WIDTH-1];
            ovf_d       = res_ovf_w;
          end
        end else if (state_q == HOLD && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      MUL: begin
        if (cnt_q != CNT_LAST) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end else begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          c_d         = res_w;
          zero_d      = (res_w == '0);
          neg_d       = res_w[WIDTH-1];
          ovf_d       = res_ovf_w;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      msign_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      msign_q     <= msign_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu : table, directed and random checks of seq_alu (WIDTH = 12)
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_alu;
  import details::*;

  localparam int    W    = 12;
  localparam longint MAXV = 2047;
  localparam longint MINV = -2048;
  localparam longint MOD  = 4096;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [W-1:0] a = '0, b = '0;
  alu_op_t selectOp = clr_alu;

  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic signed [W-1:0] c0, c1;
  logic zero0, neg0, ovf0, zero1, neg1, ovf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .selectOp(selectOp), .out_valid(out_valid0),
    .out_ready(out_ready), .c(c0), .zero(zero0), .neg(neg0), .ovf(ovf0));

  seq_alu #(.WIDTH(W), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .selectOp(selectOp), .out_valid(out_valid1),
    .out_ready(out_ready), .c(c1), .zero(zero1), .neg(neg1), .ovf(ovf1));

  typedef struct {
    alu_op_t op;
    logic signed [W-1:0] a, b, c_wrap, c_sat;
    bit ovf;
  } vec_t;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer result, then wrap or clamp to the signed range.
  function automatic void model(input logic [2:0] op, input longint av, input longint bv,
                                input bit sat, output longint cexp, output bit oexp);
    longint ex, m;
    case (op)
      3'd1:    ex = bv;
      3'd2:    ex = av + bv;
      3'd3:    ex = av - bv;
      3'd4:    ex = av * bv;
      3'd5:    ex = av + 1;
      default: ex = 0;
    endcase
    oexp = (ex > MAXV) || (ex < MINV);
    if (sat && oexp) cexp = (ex > 0) ? MAXV : MINV;
    else begin
      m = ((ex % MOD) + MOD) % MOD;
      cexp = (m > MAXV) ? m - MOD : m;
    end
  endfunction

  task automatic run_op(input alu_op_t op, input logic signed [W-1:0] av,
                        input logic signed [W-1:0] bv, output int lat, output int busy);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1; selectOp = op; a = av; b = bv;
    #1;
    while (!in_ready0 && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 100) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid0) break;
      if (!in_ready0) busy++;
    end
  endtask

  task automatic check_result(input string tag, input alu_op_t op, input int lat,
                              input int busy, input longint cw, input bit ow,
                              input longint cs);
    check({tag, "_valid"}, {out_valid0, out_valid1}, 2'b11);
    check({tag, "_c_wrap"}, c0, cw);
    check({tag, "_ovf_wrap"}, ovf0, ow);
    check({tag, "_zero_wrap"}, zero0, cw == 0);
    check({tag, "_neg_wrap"}, neg0, cw < 0);
    check({tag, "_c_sat"}, c1, cs);
    check({tag, "_ovf_sat"}, ovf1, ow);
    check({tag, "_zero_sat"}, zero1, cs == 0);
    check({tag, "_neg_sat"}, neg1, cs < 0);
    check({tag, "_latency"}, lat, (op == mul_alu) ? W + 2 : 1);
    check({tag, "_busy"}, busy, (op == mul_alu) ? W + 1 : 0);
  endtask

  initial begin
    vec_t tbl[14];
    int lat, busy;
    bit seen;
    longint cw, cs;
    bit ow, os;

    tbl[0]  = '{add_alu,  12'sd2047,  12'sd1,    -12'sd2048, 12'sd2047,  1'b1};
    tbl[1]  = '{mul_alu,  -12'sd3,    12'sd5,    -12'sd15,   -12'sd15,   1'b0};
    tbl[2]  = '{mul_alu,  12'sd100,   12'sd100,  12'sd1808,  12'sd2047,  1'b1};
    tbl[3]  = '{sub_alu,  12'sd5,     12'sd5,    12'sd0,     12'sd0,     1'b0};
    tbl[4]  = '{mul_alu,  -12'sd2048, -12'sd1,   -12'sd2048, 12'sd2047,  1'b1};
    tbl[5]  = '{mul_alu,  -12'sd2048, 12'sd1,    -12'sd2048, -12'sd2048, 1'b0};
    tbl[6]  = '{mul_alu,  12'sd0,     12'sd1234, 12'sd0,     12'sd0,     1'b0};
    tbl[7]  = '{sub_alu,  -12'sd2048, 12'sd1,    12'sd2047,  -12'sd2048, 1'b1};
    tbl[8]  = '{inc_alu,  12'sd2047,  12'sd9,    -12'sd2048, 12'sd2047,  1'b1};
    tbl[9]  = '{pass_alu, 12'sd33,    -12'sd7,   -12'sd7,    -12'sd7,    1'b0};
    tbl[10] = '{clr_alu,  12'sd44,    12'sd55,   12'sd0,     12'sd0,     1'b0};
    tbl[11] = '{alu_op_t'(3'd7), 12'sd1, 12'sd2, 12'sd0,     12'sd0,     1'b0};
    tbl[12] = '{mul_alu,  -12'sd64,   12'sd64,   12'sd0,     -12'sd2048, 1'b1};
    tbl[13] = '{add_alu,  -12'sd1000, -12'sd1000, -12'sd2000, -12'sd2000, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", {out_valid0, out_valid1}, 2'b00);
    check("rst_c", {c0, c1}, 24'd0);
    check("rst_flags", {zero0, neg0, ovf0, zero1, neg1, ovf1}, 6'd0);
    check("rst_in_ready", {in_ready0, in_ready1}, 2'b11);
    rstN = 1'b1;

    for (int i = 0; i < 14; i++)
    begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, busy);
      check_result($sformatf("vec%0d", i), tbl[i].op, lat, busy,
                   tbl[i].c_wrap, tbl[i].ovf, tbl[i].c_sat);
    end

    // Backpressure: result held while out_ready is low, next op taken on release
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; selectOp = sub_alu; a = 12'sd5; b = 12'sd5;
    @(posedge clk); #1;
    selectOp = add_alu; a = 12'sd3; b = 12'sd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {out_valid0, c0, zero0, in_ready0},
            {1'b1, 12'd0, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_on_release", in_ready0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_result", {out_valid0, c0}, {1'b1, 12'sd7});

    // Streaming: inc on 0..9, one result per cycle
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("stream%0d", i), {out_valid0, c0}, {1'b1, 12'(i)});
      check($sformatf("stream_ready%0d", i), in_ready0, 1'b1);
      in_valid = 1'b1; selectOp = inc_alu; a = 12'(i); b = '0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream10", {out_valid0, c0}, {1'b1, 12'sd10});

    // Reset in the middle of a multiply
    repeat (2) @(negedge clk);
    in_valid = 1'b1; selectOp = mul_alu; a = 12'sd7; b = 12'sd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("rstmul_state", {out_valid0, c0, in_ready0}, {1'b0, 12'd0, 1'b1});
    @(negedge clk);
    rstN = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) seen = 1'b1;
    end
    check("rstmul_no_result", seen, 1'b0);
    run_op(add_alu, 12'sd1, 12'sd1, lat, busy);
    check_result("rstmul_add", add_alu, lat, busy, 2, 1'b0, 2);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      alu_op_t rop;
      logic signed [W-1:0] ra, rb;
      rop = alu_op_t'(3'($urandom_range(0, 7)));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (i % 10 == 0) ra = (i % 20 == 0) ? -12'sd2048 : 12'sd2047;
      run_op(rop, ra, rb, lat, busy);
      model(rop, ra, rb, 1'b0, cw, ow);
      model(rop, ra, rb, 1'b1, cs, os);
      check_result($sformatf("rand%0d_op%0d_%0d_%0d", i, rop, ra, rb), rop, lat, busy,
                   cw, ow, cs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 12, meaning the operand and result width in bits (minimum 4).
REQ-002 The module SHALL have parameter SATURATE, default 0; 1 clamps overflowed results to the signed range, 0 wraps them.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rstN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: operands and opcode are valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 The module SHALL have ports a and b, input, signed WIDTH bits each: the operands.
REQ-008 The module SHALL have port selectOp, input, alu_op_t from package details: the opcode (clr_alu, pass_alu, add_alu, sub_alu, mul_alu, inc_alu).
REQ-009 The module SHALL have port out_valid, output, 1 bit: c and the flags hold a result.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The module SHALL have port c, output, signed WIDTH bits: the registered result.
REQ-012 The module SHALL have ports zero, neg and ovf, output, 1 bit each: the result is 0, the result MSB, and signed overflow.

Function
REQ-013 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b and selectOp are sampled only at that edge.
REQ-014 in_ready SHALL equal (state != MUL) and (out_valid == 0 or out_ready == 1); this is combinational from out_ready.
REQ-015 The state machine SHALL have states IDLE, MUL and HOLD; reset enters IDLE.
REQ-016 IDLE or HOLD with a non-mul accept: c and flags load at that edge, state goes to HOLD, out_valid = 1.
REQ-017 IDLE or HOLD with a mul_alu accept: state goes to MUL and out_valid clears unless it is being held.
REQ-018 HOLD without an accept: if out_ready = 1, go to IDLE and clear out_valid; otherwise hold c and flags stable.
REQ-019 MUL SHALL run an iterative shift-add on operand magnitudes, one bit per cycle, for exactly WIDTH cycles, then load the result, go to HOLD and set out_valid.
REQ-020 mul_alu latency SHALL be WIDTH+1 edges from the accept edge to out_valid rising; throughput is one mul per WIDTH+1 cycles.
REQ-021 Non-mul latency SHALL be 1 edge; back-to-back non-mul throughput is 1 per cycle while out_ready = 1.
REQ-022 Results: clr gives 0; pass gives b; add gives a+b; sub gives a-b; inc gives a+1; mul gives the low WIDTH bits of the 2*WIDTH signed product; any other code gives 0.
REQ-023 ovf SHALL be 1 when the exact signed result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; it is always 0 for clr, pass and undefined codes.
REQ-024 With SATURATE = 1 and ovf = 1, c SHALL be 2^(WIDTH-1)-1 for a positive exact result and -2^(WIDTH-1) for a negative one.
REQ-025 zero and neg SHALL be computed from the final c after wrap or saturation.
REQ-026 mul with either operand 0 SHALL still take WIDTH+1 cycles and give c = 0, zero = 1.
REQ-027 mul by -2^(WIDTH-1) SHALL be exact; the magnitude path is WIDTH+1 bits wide.
REQ-028 in_valid during MUL SHALL be ignored (in_ready = 0); the operation is not lost, it stays pending at the source.

Reset
REQ-029 While rstN = 0: state IDLE; out_valid, c, zero, neg and ovf are 0; the multiplier registers are cleared; in_ready = 1.
REQ-030 rstN asserting mid-MUL or in HOLD SHALL abort the operation immediately; no result is produced after release.
REQ-031 After release the block SHALL accept an operation on the first rising edge.

Verification (WIDTH = 12)
REQ-032 add 2047+1 with SATURATE = 0: c = -2048, ovf = 1, neg = 1; with SATURATE = 1: c = 2047, ovf = 1, neg = 0.
REQ-033 mul -3*5 with out_ready = 1: in_ready = 0 for 13 cycles, out_valid rises 13 edges after accept, c = -15, ovf = 0.
REQ-034 mul 100*100: SATURATE = 0 gives c = 1808 (10000 mod 4096), ovf = 1; SATURATE = 1 gives c = 2047.
REQ-035 Backpressure: out_ready = 0 for 5 cycles after sub 5-5: c = 0 and zero = 1 stay stable, in_ready = 0, and a new op is accepted in the same cycle out_ready = 1.
REQ-036 Streaming: inc on 0..9 in consecutive cycles with out_ready = 1 gives outputs 1..10 on consecutive cycles with no bubble.
REQ-037 Reset mid-mul: rstN = 0 at cycle 6 of MUL gives out_valid = 0, c = 0 and in_ready = 1; a following add 1+1 gives c = 2 after 1 edge.
